// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer
//   Instruction prefetch queue sitting between the fetch unit and the IF port
//   of the SRAM arbiter. Sequential words are requested ahead of demand and
//   parked in a small FIFO. Fetch requests that match the FIFO head are served
//   combinationally. A branch redirect (IF_flush) or an out-of-sequence fetch
//   address clears the FIFO and restarts prefetch at the new target. An
//   arbiter transfer that is already in flight is always completed; its data
//   is dropped if it became stale.
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   When defined, a word returning from the arbiter while the FIFO is empty
//   is handed straight to a matching fetch request in the same cycle.
//
// Ports
//   clk, reset          : single rising-edge clock, synchronous active-high reset
//   instr_req/instr_addr: fetch unit request (instr_addr[1:0] ignored)
//   instr/instr_ready   : returned word, combinational hit (pops the FIFO)
//   IF_flush/branch_PC  : branch redirect pulse and its target
//   IF_req/IF_we/IF_addr/IF_wdata : arbiter request side (read only)
//   IF_rdata/IF_ready   : arbiter completion (one-cycle pulse)
//   buf_count           : FIFO occupancy
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       instr_req,
  input  logic [31:0]                instr_addr,
  output logic [31:0]                instr,
  output logic                       instr_ready,
  input  logic                       IF_flush,
  input  logic [31:0]                branch_PC,
  output logic                       IF_req,
  output logic                       IF_we,
  output logic [31:0]                IF_addr,
  output logic [31:0]                IF_wdata,
  input  logic [31:0]                IF_rdata,
  input  logic                       IF_ready,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  // Addresses are kept as word addresses (byte address bits [31:2]).
  logic [29:0]     fetch_addr_q, fetch_addr_d;
  logic [29:0]     if_addr_q, if_addr_d;
  logic            if_req_q, if_req_d;

  logic [29:0]     addr_mem [DEPTH];
  logic [31:0]     data_mem [DEPTH];

  logic            fifo_empty;
  logic [29:0]     head_addr;
  logic [31:0]     head_data;
  logic [29:0]     req_word;
  logic [29:0]     expected_addr;
  logic [29:0]     redirect_target;
  logic            mismatch;
  logic            redirect;
  logic            hit;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            unused_low_bits;

  assign unused_low_bits = ^{instr_addr[1:0], branch_PC[1:0]};

  assign fifo_empty = (count_q == '0);
  assign head_addr  = addr_mem[rd_ptr_q];
  assign head_data  = data_mem[rd_ptr_q];
  assign req_word   = instr_addr[31:2];

  // The address the fetch unit is expected to ask for next: the oldest
  // buffered word, else the word in flight, else the next word to request.
  always_comb begin
    if (!fifo_empty) begin
      expected_addr = head_addr;
    end else if (state_q == S_REQ) begin
      expected_addr = if_addr_q;
    end else begin
      expected_addr = fetch_addr_q;
    end
  end

  // A flush outranks an out-of-sequence fetch as redirect source.
  assign mismatch        = instr_req && (req_word != expected_addr);
  assign redirect        = IF_flush || mismatch;
  assign redirect_target = IF_flush ? branch_PC[31:2] : req_word;

  // No word is delivered in a redirect cycle.
  assign hit = instr_req && !fifo_empty && (req_word == head_addr) && !redirect;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = instr_req && fifo_empty && (state_q == S_REQ) && IF_ready &&
                  (req_word == if_addr_q) && !redirect;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = hit;
  // A bypassed word is consumed directly and never enters the FIFO.
  assign push = (state_q == S_REQ) && IF_ready && !redirect && !bypass;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fetch_addr_d = fetch_addr_q;
    if_addr_d    = if_addr_q;
    if_req_d     = if_req_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (!redirect && (count_q < CW'(DEPTH))) begin
          state_d      = S_REQ;
          if_req_d     = 1'b1;
          if_addr_d    = fetch_addr_q;
          fetch_addr_d = fetch_addr_q + 30'd1;
        end
      end
      S_REQ: begin
        // A redirect makes the in-flight word stale even if it is returning
        // right now, so it is routed to DISCARD rather than pushed.
        if (redirect) begin
          state_d = S_DISCARD;
        end else if (IF_ready) begin
          state_d  = S_IDLE;
          if_req_d = 1'b0;
        end
      end
      S_DISCARD: begin
        if (IF_ready) begin
          state_d  = S_IDLE;
          if_req_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        if_req_d = 1'b0;
      end
    endcase

    if (redirect) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      fetch_addr_d = redirect_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fetch_addr_q <= RESET_PC[31:2];
      if_addr_q    <= '0;
      if_req_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fetch_addr_q <= fetch_addr_d;
      if_addr_q    <= if_addr_d;
      if_req_q     <= if_req_d;
    end
  end

  // FIFO storage carries no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= if_addr_q;
      data_mem[wr_ptr_q] <= IF_rdata;
    end
  end

  assign instr_ready = hit || bypass;
  assign instr       = bypass ? IF_rdata : (hit ? head_data : 32'h0);
  assign IF_req      = if_req_q;
  assign IF_addr     = {if_addr_q, 2'b00};
  assign IF_we       = 1'b0;
  assign IF_wdata    = 32'h0;
  assign buf_count   = count_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Testbench for instr_prefetch_buffer: randomized fetch/arbiter traffic
// checked each cycle against a queue-based reference model.
module tb_instr_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH+1);
  localparam int          NCYC     = 4000;
  localparam int          FILL_END = 40;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          instr_req  = 1'b0;
  logic [31:0]   instr_addr = 32'h0;
  logic          IF_flush   = 1'b0;
  logic [31:0]   branch_PC  = 32'h0;
  logic [31:0]   IF_rdata   = 32'h0;
  logic          IF_ready   = 1'b0;
  logic [31:0]   instr;
  logic          instr_ready;
  logic          IF_req;
  logic          IF_we;
  logic [31:0]   IF_addr;
  logic [31:0]   IF_wdata;
  logic [CW-1:0] buf_count;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr       (instr),
    .instr_ready (instr_ready),
    .IF_flush    (IF_flush),
    .branch_PC   (branch_PC),
    .IF_req      (IF_req),
    .IF_we       (IF_we),
    .IF_addr     (IF_addr),
    .IF_wdata    (IF_wdata),
    .IF_rdata    (IF_rdata),
    .IF_ready    (IF_ready),
    .buf_count   (buf_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model: buffered word addresses, next prefetch address and
  // the single outstanding arbiter request (possibly marked stale).
  logic [31:0] m_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_req_addr;
  bit          m_busy;
  bit          m_discard;

  initial begin
    int          arb_cnt;
    int          old_size;
    logic [31:0] pc;
    logic [31:0] e_expected;
    logic [31:0] e_target;
    logic [31:0] e_instr;
    bit          e_redirect;
    bit          e_hit;
    bit          e_bypass;
    bit          fill;

    m_q.delete();
    m_fetch    = RESET_PC;
    m_req_addr = 32'h0;
    m_busy     = 1'b0;
    m_discard  = 1'b0;
    pc         = RESET_PC;
    arb_cnt    = 1;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_IF_req", {31'h0, IF_req}, 32'h0);
    check_val("rst_IF_addr", IF_addr, 32'h0);
    check_val("rst_IF_we", {31'h0, IF_we}, 32'h0);
    check_val("rst_IF_wdata", IF_wdata, 32'h0);
    check_val("rst_instr_ready", {31'h0, instr_ready}, 32'h0);
    check_val("rst_instr", instr, 32'h0);
    check_val("rst_buf_count", 32'(buf_count), 32'h0);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      fill  = (cyc < FILL_END);
      reset = !fill && ($urandom_range(0, 399) == 0);

      // Arbiter: completes each request after 0..3 wait cycles (1 while filling).
      if (reset || !IF_req) begin
        IF_ready = 1'b0;
        arb_cnt  = fill ? 1 : int'($urandom_range(0, 3));
      end else if (arb_cnt == 0) begin
        IF_ready = 1'b1;
        arb_cnt  = fill ? 1 : int'($urandom_range(0, 3));
      end else begin
        IF_ready = 1'b0;
        arb_cnt--;
      end
      IF_rdata = IF_ready ? memf(IF_addr) : $urandom;

      // Fetch unit: walks sequentially, occasionally jumps or branches.
      if (fill) begin
        instr_req = 1'b0;
        IF_flush  = 1'b0;
      end else begin
        if ($urandom_range(0, 19) == 0) pc = $urandom_range(0, 1023) * 4;
        instr_req  = ($urandom_range(0, 2) != 0);
        instr_addr = pc | 32'($urandom_range(0, 3));
        IF_flush   = ($urandom_range(0, 29) == 0);
        branch_PC  = $urandom;
      end

      #1;
      if (m_q.size() > 0)            e_expected = m_q[0];
      else if (m_busy && !m_discard) e_expected = m_req_addr;
      else                           e_expected = m_fetch;
      e_redirect = IF_flush || (instr_req && (instr_addr[31:2] != e_expected[31:2]));
      e_target   = IF_flush ? (branch_PC & ~32'h3) : (instr_addr & ~32'h3);
      e_hit      = !e_redirect && instr_req && (m_q.size() > 0);
`ifdef PREFETCH_BYPASS_EN
      e_bypass   = !e_redirect && instr_req && (m_q.size() == 0) && m_busy && !m_discard && IF_ready;
`else
      e_bypass   = 1'b0;
`endif
      if (e_hit)         e_instr = memf(m_q[0]);
      else if (e_bypass) e_instr = memf(m_req_addr);
      else               e_instr = 32'h0;

      check_val("instr_ready", {31'h0, instr_ready}, {31'h0, e_hit || e_bypass});
      check_val("instr", instr, e_instr);
      check_val("IF_req", {31'h0, IF_req}, {31'h0, m_busy});
      check_val("IF_addr", IF_addr, m_req_addr);
      check_val("buf_count", 32'(buf_count), 32'(m_q.size()));
      if (cyc == FILL_END - 1) begin
        check_val("fill_count", 32'(buf_count), 32'(DEPTH));
        check_val("fill_idle", {31'h0, IF_req}, 32'h0);
      end
      if ((e_hit || e_bypass) && instr_ready)
        $display("[TB] cyc %0d fetch %08h -> %08h", cyc, instr_addr & ~32'h3, instr);

      @(posedge clk);
      if (reset) begin
        m_q.delete();
        m_fetch    = RESET_PC;
        m_req_addr = 32'h0;
        m_busy     = 1'b0;
        m_discard  = 1'b0;
        pc         = RESET_PC;
      end else begin
        old_size = m_q.size();
        if (e_hit) begin
          void'(m_q.pop_front());
          pc = pc + 32'd4;
        end
        if (e_bypass) pc = pc + 32'd4;
        if (e_redirect) begin
          m_q.delete();
          m_fetch = e_target;
          pc      = e_target;
          if (m_busy && !m_discard) begin
            m_discard = 1'b1;
          end else if (m_busy && IF_ready) begin
            m_busy    = 1'b0;
            m_discard = 1'b0;
          end
        end else if (m_busy && IF_ready) begin
          if (!m_discard && !e_bypass) m_q.push_back(m_req_addr);
          m_busy    = 1'b0;
          m_discard = 1'b0;
        end else if (!m_busy && (old_size < DEPTH)) begin
          m_busy     = 1'b1;
          m_req_addr = m_fetch;
          m_fetch    = m_fetch + 32'd4;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
# instr_prefetch_buffer

Instruction prefetch queue between the fetch unit and the IF port of the SRAM arbiter. Streams sequential instruction words from SRAM into a small FIFO ahead of demand, serves fetch-unit requests from the FIFO, and discards stale words on branch redirects. The arbiter handshake is never abandoned mid-transfer.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first prefetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_req  in  1  fetch unit requests word at instr_addr.
- instr_addr  in  32  requested PC; bits [1:0] ignored.
- instr  out  32  instruction word; valid when instr_ready.
- instr_ready  out  1  combinational hit; pops FIFO head.
- IF_flush  in  1  branch redirect pulse.
- branch_PC  in  32  redirect target, sampled with IF_flush.
- IF_req  out  1  arbiter request.
- IF_we  out  1  tied 0.
- IF_addr  out  32  word address of request.
- IF_wdata  out  32  tied 0.
- IF_rdata  in  32  read data; valid with IF_ready.
- IF_ready  in  1  one-cycle completion pulse.
- buf_count  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Each FIFO entry holds {addr[31:2], data[31:0]}. fetch_addr is the next word to request; it advances by 4 on each request issue.
- Memory FSM:
  - IDLE: IF_req=0. Go to REQ when count<DEPTH and no redirect this cycle, latching IF_addr<=fetch_addr and fetch_addr+=4.
  - REQ: IF_req=1 with IF_addr held. On IF_ready, push {IF_addr, IF_rdata} and go to IDLE.
  - DISCARD: IF_req=1 with IF_addr held. On IF_ready, drop the data and go to IDLE.
- Expected address:
  - head addr if count>0;
  - else IF_addr in REQ;
  - else fetch_addr.
- Hit: instr_req && count>0 && instr_addr[31:2]==head addr.
  - instr_ready=1, instr=head data, pop.
  - When no hit, instr=0.
- Redirect sources:
  - IF_flush, target branch_PC;
  - instr_req with instr_addr[31:2] != expected, target instr_addr.
  - IF_flush wins when both occur in one cycle.
- On redirect:
  - Clear FIFO (count<=0, pointers<=0); fetch_addr<=target&~3; no instr_ready that cycle.
  - REQ goes to DISCARD, even if IF_ready arrives the same cycle; that word is dropped. IDLE stays IDLE.
  - A redirect in DISCARD only updates fetch_addr.
- Push and pop in the same cycle leave count unchanged. Push never occurs when full, because issue requires count<DEPTH and only one request is outstanding.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - State IDLE, fetch_addr=RESET_PC, count=0.
  - IF_req=0, IF_addr=0, IF_we=0, IF_wdata=0.
  - instr_ready=0, instr=0, buf_count=0.
- First IF_req rises in the first cycle after reset deasserts.
- Hit latency: 0 cycles, combinational from instr_req/instr_addr.
- Miss on empty FIFO, arbiter ready N cycles after req: word in FIFO at IF_ready edge; instr_ready the following cycle.
- Steady state: one request every 2+N cycles (the IDLE cycle is mandatory between requests).
- Reset mid-transfer: IF_req drops the next cycle and the FIFO is cleared. The arbiter shares the reset, so no discard is needed.

## Configuration
- PREFETCH_BYPASS_EN
  - Defined: in REQ with FIFO empty, IF_ready asserted, instr_req and instr_addr[31:2]==IF_addr[31:2] → instr_ready=1 and instr=IF_rdata in the same cycle. The word is not pushed. Miss latency drops by one cycle.
  - Undefined: returned words always go through the FIFO.

## Test plan
- Reset, RESET_PC=0, arbiter ready 1 cycle after req, fetch idle → IF_addr 0,4,8,12 issued; buf_count reaches 4; IF_req stays 0 while full.
- Full FIFO, instr_req at 0,4,8 on consecutive cycles → instr_ready high each cycle with matching data; refill requests issued at 16, 20.
- IF_flush with branch_PC=0x100 while REQ at 0x14 → IF_req held until IF_ready; data dropped; buf_count=0; next IF_addr=0x100.
- instr_req at 0x40 while head=0x8 → FIFO cleared, next request 0x40; instr_ready with word from 0x40 after return (+1 cycle without bypass).
- IF_flush to 0x200 and instr_req mismatch to 0x300 in the same cycle → next request 0x200.
- With PREFETCH_BYPASS_EN, empty FIFO, instr_req 0x0 → instr_ready in the IF_ready cycle, buf_count stays 0; without the macro → one cycle later.
